spi_seg_mux_controller: RTL and testbench

//  - Multi-digit 7-segment display controller. Digit contents and modes are loaded over a mode-0 SPI slave.
//  - Time-multiplexes NUM_DIGITS digits using a prescaled scan tick.
//  - Adds per-digit blink, hex decode and global display enable.
//  - Sits between the chip inputs (SPI on ui_in) and the display pins (uo_out = segments, uio_out = digit enables).

---
 rtl/spi_seg_mux_controller_pkg.sv | 41 ++++
 rtl/spi_seg_mux_controller_if.sv | 21 ++
 rtl/spi_seg_mux_controller_spi_frame_rx.sv | 104 ++++++++++
 rtl/spi_seg_mux_controller.sv | 168 ++++++++++++++++
 tb/tb_spi_seg_mux_controller.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_seg_mux_controller_pkg.sv
// Shared constants, receiver state encoding and the hex-to-segment decoder
// for the SPI-loaded 7-segment scan controller.
package seg_pkg;

    localparam int FRAME_BITS = 16;

    localparam logic [3:0] CMD_RAW   = 4'h1;
    localparam logic [3:0] CMD_HEX   = 4'h2;
    localparam logic [3:0] CMD_BLINK = 4'h3;
    localparam logic [3:0] CMD_ENA   = 4'h4;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_SHIFT = 2'd1,
        RX_WAIT  = 2'd2
    } rx_state_e;

    // Segment order {g,f,e,d,c,b,a}, active high
    function automatic logic [6:0] hex7(input logic [3:0] v);
        case (v)
            4'h0:    hex7 = 7'h3F;
            4'h1:    hex7 = 7'h06;
            4'h2:    hex7 = 7'h5B;
            4'h3:    hex7 = 7'h4F;
            4'h4:    hex7 = 7'h66;
            4'h5:    hex7 = 7'h6D;
            4'h6:    hex7 = 7'h7D;
            4'h7:    hex7 = 7'h07;
            4'h8:    hex7 = 7'h7F;
            4'h9:    hex7 = 7'h6F;
            4'hA:    hex7 = 7'h77;
            4'hB:    hex7 = 7'h7C;
            4'hC:    hex7 = 7'h39;
            4'hD:    hex7 = 7'h5E;
            4'hE:    hex7 = 7'h79;
            4'hF:    hex7 = 7'h71;
            default: hex7 = 7'h00;
        endcase
    endfunction

endpackage

// File: rtl/spi_seg_mux_controller_if.sv
// SPI input pins and display output pins of the scan controller.
interface spi_seg_mux_controller_if #(
    parameter int NUM_DIGITS = 4
);
    logic                  spi_sck;
    logic                  spi_cs_n;
    logic                  spi_mosi;
    logic [7:0]            seg_out;
    logic [NUM_DIGITS-1:0] dig_en;
    logic                  frame_done;

    modport master (
        output spi_sck, spi_cs_n, spi_mosi,
        input  seg_out, dig_en, frame_done
    );

    modport slave (
        input  spi_sck, spi_cs_n, spi_mosi,
        output seg_out, dig_en, frame_done
    );
endinterface

// File: rtl/spi_seg_mux_controller_spi_frame_rx.sv
// Mode-0 SPI slave: synchronises the pins into clk, counts 16 bits MSB first
// and presents the completed frame combinationally for one clk.
module spi_frame_rx
    import seg_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  sck_i,
    input  logic                  cs_n_i,
    input  logic                  mosi_i,
    output logic                  frame_valid_o,
    output logic [FRAME_BITS-1:0] frame_o
);

    logic [2:0]            sck_sync_q;
    logic [1:0]            cs_sync_q;
    logic [1:0]            mosi_sync_q;
    rx_state_e             state_q, state_d;
    logic [4:0]            cnt_q, cnt_d;
    logic [FRAME_BITS-1:0] shift_q, shift_d;
    logic                  sck_rise_s;
    logic                  cs_n_s;
    logic                  mosi_s;

    // Bit [2] of the sck chain is only the edge-detect history, not a sync stage
    assign sck_rise_s = sck_sync_q[1] & ~sck_sync_q[2];
    assign cs_n_s     = cs_sync_q[1];
    assign mosi_s     = mosi_sync_q[1];

    // Two-flop synchronisers; cs_n resets high so no frame starts out of reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sck_sync_q  <= 3'b000;
            cs_sync_q   <= 2'b11;
            mosi_sync_q <= 2'b00;
        end else begin
            sck_sync_q  <= {sck_sync_q[1:0], sck_i};
            cs_sync_q   <= {cs_sync_q[0], cs_n_i};
            mosi_sync_q <= {mosi_sync_q[0], mosi_i};
        end
    end

    // Receiver state, bit counter and shift register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= RX_IDLE;
            cnt_q   <= 5'd0;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
        end
    end

    // Frame sequencing; after 16 bits everything is ignored until cs_n rises
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        shift_d       = shift_q;
        frame_valid_o = 1'b0;
        frame_o       = shift_q;
        case (state_q)
            RX_IDLE: begin
                cnt_d = 5'd0;
                if (!cs_n_s) begin
                    state_d = RX_SHIFT;
                end else begin
                    state_d = RX_IDLE;
                end
            end
            RX_SHIFT: begin
                if (cs_n_s) begin
                    state_d = RX_IDLE;
                    cnt_d   = 5'd0;
                end else if (sck_rise_s) begin
                    shift_d = {shift_q[FRAME_BITS-2:0], mosi_s};
                    if (cnt_q == 5'(FRAME_BITS - 1)) begin
                        frame_valid_o = 1'b1;
                        frame_o       = shift_d;
                        cnt_d         = 5'd0;
                        state_d       = RX_WAIT;
                    end else begin
                        cnt_d = cnt_q + 5'd1;
                    end
                end else begin
                    state_d = RX_SHIFT;
                end
            end
            RX_WAIT: begin
                if (cs_n_s) begin
                    state_d = RX_IDLE;
                end else begin
                    state_d = RX_WAIT;
                end
            end
            default: begin
                state_d = RX_IDLE;
                cnt_d   = 5'd0;
            end
        endcase
    end

endmodule

// File: rtl/spi_seg_mux_controller.sv
// Multiplexed 7-segment display controller: command decode, digit registers,
// scan/blink timing and the registered segment/digit-enable outputs.
module spi_seg_mux_controller
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int TICK_DIV    = 10000,
    parameter int BLINK_TICKS = 256
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       ena,
    spi_seg_mux_controller_if.slave    bus
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int PRE_W = $clog2(TICK_DIV);
    localparam int BLK_W = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(NUM_DIGITS - 1);
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICK_DIV - 1);
    localparam logic [BLK_W-1:0] BLK_MAX = BLK_W'(BLINK_TICKS - 1);

    logic                  frame_valid_s;
    logic [FRAME_BITS-1:0] frame_s;
    logic [3:0]            cmd_s;
    logic [3:0]            addr_s;
    logic [7:0]            data_s;
    logic                  addr_ok_s;
    logic                  tick_s;
    logic                  blank_s;

    logic [7:0]            digit_q [NUM_DIGITS];
    logic [7:0]            digit_d [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] blink_mask_q, blink_mask_d;
    logic                  display_en_q, display_en_d;
    logic [PRE_W-1:0]      pre_q, pre_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [BLK_W-1:0]      blk_q, blk_d;
    logic                  phase_on_q, phase_on_d;
    logic [7:0]            seg_q, seg_d;
    logic [NUM_DIGITS-1:0] dig_en_q, dig_en_d;
    logic                  frame_done_q, frame_done_d;

    spi_frame_rx u_rx (
        .clk           (clk),
        .rst_n         (rst_n),
        .sck_i         (bus.spi_sck),
        .cs_n_i        (bus.spi_cs_n),
        .mosi_i        (bus.spi_mosi),
        .frame_valid_o (frame_valid_s),
        .frame_o       (frame_s)
    );

    assign cmd_s     = frame_s[15:12];
    assign addr_s    = frame_s[11:8];
    assign data_s    = frame_s[7:0];
    assign addr_ok_s = (32'(addr_s) < 32'(NUM_DIGITS));
    assign tick_s    = ena && (pre_q == PRE_MAX);

    // Command decode; only accepted frames raise frame_done
    always_comb begin
        digit_d      = digit_q;
        blink_mask_d = blink_mask_q;
        display_en_d = display_en_q;
        frame_done_d = 1'b0;
        if (frame_valid_s) begin
            case (cmd_s)
                CMD_RAW: begin
                    if (addr_ok_s) begin
                        digit_d[addr_s[IDX_W-1:0]] = data_s;
                        frame_done_d               = 1'b1;
                    end else begin
                        frame_done_d = 1'b0;
                    end
                end
                CMD_HEX: begin
                    if (addr_ok_s) begin
                        digit_d[addr_s[IDX_W-1:0]] = {data_s[7], hex7(data_s[3:0])};
                        frame_done_d               = 1'b1;
                    end else begin
                        frame_done_d = 1'b0;
                    end
                end
                CMD_BLINK: begin
                    blink_mask_d = data_s[NUM_DIGITS-1:0];
                    frame_done_d = 1'b1;
                end
                CMD_ENA: begin
                    display_en_d = data_s[0];
                    frame_done_d = 1'b1;
                end
                default: begin
                    frame_done_d = 1'b0;
                end
            endcase
        end else begin
            frame_done_d = 1'b0;
        end
    end

    // Prescaler, scan index and blink phase; all frozen while ena is low
    always_comb begin
        pre_d      = pre_q;
        idx_d      = idx_q;
        blk_d      = blk_q;
        phase_on_d = phase_on_q;
        if (tick_s) begin
            pre_d = '0;
            idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + IDX_W'(1);
            if (blk_q == BLK_MAX) begin
                blk_d      = '0;
                phase_on_d = ~phase_on_q;
            end else begin
                blk_d = blk_q + BLK_W'(1);
            end
        end else if (ena) begin
            pre_d = pre_q + PRE_W'(1);
        end else begin
            pre_d = pre_q;
        end
    end

    // Output stage sees current idx/digit state, so pins lag them by one clk
    always_comb begin
        blank_s = !display_en_q || !ena || (blink_mask_q[idx_q] && !phase_on_q);
        if (blank_s) begin
            seg_d    = 8'h00;
            dig_en_d = '0;
        end else begin
            seg_d    = digit_q[idx_q];
            dig_en_d = NUM_DIGITS'(1'b1) << idx_q;
        end
    end

    // All controller state and output registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                digit_q[i] <= 8'h00;
            end
            blink_mask_q <= '0;
            display_en_q <= 1'b1;
            pre_q        <= '0;
            idx_q        <= '0;
            blk_q        <= '0;
            phase_on_q   <= 1'b1;
            seg_q        <= 8'h00;
            dig_en_q     <= '0;
            frame_done_q <= 1'b0;
        end else begin
            digit_q      <= digit_d;
            blink_mask_q <= blink_mask_d;
            display_en_q <= display_en_d;
            pre_q        <= pre_d;
            idx_q        <= idx_d;
            blk_q        <= blk_d;
            phase_on_q   <= phase_on_d;
            seg_q        <= seg_d;
            dig_en_q     <= dig_en_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign bus.seg_out    = seg_q;
    assign bus.dig_en     = dig_en_q;
    assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_spi_seg_mux_controller.sv
// Directed bench for the SPI 7-segment scan controller with a small scan model
// for the blink, enable and reset windows.
module tb_spi_seg_mux_controller;

    localparam int ND   = 4;
    localparam int TD   = 8;
    // Three ticks per blink half keeps the blink period out of step with the scan
    localparam int BT   = 3;
    localparam int HALF = 4;

    logic clk;
    logic rst_n;
    logic ena;

    int n_checks;
    int n_fail;
    int fd_cnt;
    int fd_base;

    logic [7:0]    exp_digit [ND];
    logic [ND-1:0] m_mask;
    logic          m_den;
    int            m_pre;
    int            m_idx;
    int            m_bc;
    logic          m_on;
    logic [ND-1:0] exp_dig;
    logic [7:0]    exp_seg;

    int         walk_m   [8] = '{1, 8, 9, 16, 17, 25, 32, 33};
    logic [3:0] walk_exp [8] = '{4'b0001, 4'b0001, 4'b0010, 4'b0010,
                                 4'b0100, 4'b1000, 4'b1000, 4'b0001};

    spi_seg_mux_controller_if #(.NUM_DIGITS(ND)) bus ();

    spi_seg_mux_controller #(
        .NUM_DIGITS  (ND),
        .TICK_DIV    (TD),
        .BLINK_TICKS (BT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ena   (ena),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.frame_done === 1'b1) fd_cnt <= fd_cnt + 1;
    end

    // Reference scan model: outputs after an edge reflect state before it
    always @(posedge clk) begin
        if (!rst_n) begin
            m_pre   <= 0;
            m_idx   <= 0;
            m_bc    <= 0;
            m_on    <= 1'b1;
            exp_dig <= '0;
            exp_seg <= 8'h00;
        end else begin
            if (!ena || !m_den || (m_mask[m_idx] && !m_on)) begin
                exp_dig <= '0;
                exp_seg <= 8'h00;
            end else begin
                exp_dig <= ND'(1) << m_idx;
                exp_seg <= exp_digit[m_idx];
            end
            if (ena) begin
                if (m_pre == TD - 1) begin
                    m_pre <= 0;
                    m_idx <= (m_idx == ND - 1) ? 0 : m_idx + 1;
                    if (m_bc == BT - 1) begin
                        m_bc <= 0;
                        m_on <= !m_on;
                    end else begin
                        m_bc <= m_bc + 1;
                    end
                end else begin
                    m_pre <= m_pre + 1;
                end
            end
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic spi_bits(input logic [15:0] v, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            bus.spi_mosi = v[15 - i];
            clks(HALF);
            bus.spi_sck = 1'b1;
            clks(HALF);
            bus.spi_sck = 1'b0;
        end
    endtask

    task automatic send_frame(input logic [15:0] v, input int nbits);
        bus.spi_cs_n = 1'b0;
        clks(HALF);
        spi_bits(v, nbits);
        clks(HALF);
        bus.spi_cs_n = 1'b1;
        clks(2 * HALF);
    endtask

    task automatic wait_digit(input string tag, input int idx, input logic [7:0] exp);
        logic [ND-1:0] want;
        bit            found;
        want  = ND'(1) << idx;
        found = 1'b0;
        for (int i = 0; i < 4 * TD * ND && !found; i++) begin
            @(negedge clk);
            if (bus.dig_en === want) found = 1'b1;
        end
        if (found) check_eq(tag, 32'(bus.seg_out), 32'(exp));
        else       check_eq({tag, "_timeout"}, 32'(bus.dig_en), 32'(want));
    endtask

    task automatic model_window(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check_eq({tag, "_dig"}, 32'(bus.dig_en), 32'(exp_dig));
            check_eq({tag, "_seg"}, 32'(bus.seg_out), 32'(exp_seg));
        end
    endtask

    task automatic clear_model;
        for (int i = 0; i < ND; i++) exp_digit[i] = 8'h00;
        m_mask = '0;
        m_den  = 1'b1;
    endtask

    initial begin
        n_checks     = 0;
        n_fail       = 0;
        fd_cnt       = 0;
        rst_n        = 1'b0;
        ena          = 1'b1;
        bus.spi_sck  = 1'b0;
        bus.spi_cs_n = 1'b1;
        bus.spi_mosi = 1'b0;
        clear_model();

        clks(3);
        check_eq("rst_seg", 32'(bus.seg_out), 32'h0);
        check_eq("rst_dig", 32'(bus.dig_en), 32'h0);
        check_eq("rst_fd", 32'(bus.frame_done), 32'h0);

        // Scan walk after reset, one clk behind each tick
        rst_n = 1'b1;
        for (int m = 1, k = 0; m <= 4 * TD + 1; m++) begin
            @(negedge clk);
            check_eq("walk_nox", 32'($isunknown({bus.seg_out, bus.dig_en, bus.frame_done})), 32'h0);
            if (k < 8 && m == walk_m[k]) begin
                check_eq("walk_dig", 32'(bus.dig_en), 32'(walk_exp[k]));
                check_eq("walk_seg", 32'(bus.seg_out), 32'h0);
                k++;
            end
        end

        // Hex writes to all four digits
        fd_base = fd_cnt;
        send_frame(16'h2003, 16);
        send_frame(16'h211A, 16);
        send_frame(16'h2200, 16);
        send_frame(16'h230F, 16);
        check_eq("hex_fd", 32'(fd_cnt - fd_base), 32'd4);
        wait_digit("hex_d0", 0, 8'h4F);
        wait_digit("hex_d1", 1, 8'h77);
        wait_digit("hex_d2", 2, 8'h3F);
        wait_digit("hex_d3", 3, 8'h71);

        // Raw write, then an out-of-range address that must be dropped
        fd_base = fd_cnt;
        send_frame(16'h10FF, 16);
        send_frame(16'h1455, 16);
        check_eq("raw_fd", 32'(fd_cnt - fd_base), 32'd1);
        wait_digit("raw_d0", 0, 8'hFF);
        wait_digit("raw_d1", 1, 8'h77);
        wait_digit("raw_d3", 3, 8'h71);

        // Truncated frame discarded, following full frame accepted
        fd_base = fd_cnt;
        send_frame(16'h2005, 8);
        send_frame(16'h2105, 16);
        check_eq("part_fd", 32'(fd_cnt - fd_base), 32'd1);
        wait_digit("part_d0", 0, 8'hFF);
        wait_digit("part_d1", 1, 8'h6D);

        exp_digit[0] = 8'hFF;
        exp_digit[1] = 8'h6D;
        exp_digit[2] = 8'h3F;
        exp_digit[3] = 8'h71;

        // Blink digit 1
        fd_base = fd_cnt;
        send_frame(16'h3002, 16);
        check_eq("blink_fd", 32'(fd_cnt - fd_base), 32'd1);
        m_mask = 4'b0010;
        model_window("blink", 2 * BT * ND * TD);

        // ena low blanks and freezes the scan; releasing it resumes in place
        ena = 1'b0;
        model_window("ena_lo", 3 * TD);
        ena = 1'b1;
        model_window("ena_hi", 2 * TD);

        // Global display disable
        fd_base = fd_cnt;
        send_frame(16'h4000, 16);
        check_eq("dis_fd", 32'(fd_cnt - fd_base), 32'd1);
        m_den = 1'b0;
        model_window("dis", 2 * TD);

        // Reset in the middle of a frame
        fd_base = fd_cnt;
        bus.spi_cs_n = 1'b0;
        clks(HALF);
        spi_bits(16'h1012, 6);
        rst_n = 1'b0;
        clear_model();
        clks(3);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("rst_mid_dig", 32'(bus.dig_en), 32'h1);
        check_eq("rst_mid_seg", 32'(bus.seg_out), 32'h0);
        spi_bits(16'h1012, 4);
        bus.spi_cs_n = 1'b1;
        clks(2 * HALF);
        check_eq("rst_mid_fd", 32'(fd_cnt - fd_base), 32'd0);
        model_window("post_rst", TD);

        fd_base = fd_cnt;
        send_frame(16'h4001, 16);
        check_eq("ena_fd", 32'(fd_cnt - fd_base), 32'd1);
        model_window("reena", ND * TD);
        wait_digit("reena_d0", 0, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
